// File: rtl/l1_trig_wb_pkg.sv
// Shared constants and types for the L1 trigger Wishbone interconnect.
package l1_trig_wb_pkg;

  localparam int ADDR_W_DEF     = 15;
  localparam int SUB_ADDR_W_DEF = 13;
  localparam int DATA_W_DEF     = 32;

  localparam logic [1:0] SP_THRESH  = 2'd0;
  localparam logic [1:0] SP_CONTROL = 2'd1;
  localparam logic [1:0] SP_AGC     = 2'd2;
  localparam logic [1:0] SP_BQ      = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_LOCAL = 2'd2
  } state_e;

endpackage

// File: rtl/l1_trig_wb_timeout.sv
// Loadable down-counter; expired_o is high once the loaded budget has run out.
module l1_trig_wb_timeout #(
  parameter int CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/l1_trig_wb_intercon.sv
// Wishbone classic 1-to-4 interconnect: decode, single-transaction FSM, local
// completion for gated subspaces and timeout termination of silent targets.
module l1_trig_wb_intercon
  import l1_trig_wb_pkg::*;
#(
  parameter int          ADDR_WIDTH     = ADDR_W_DEF,
  parameter int          SUB_ADDR_WIDTH = SUB_ADDR_W_DEF,
  parameter int          DATA_WIDTH     = DATA_W_DEF,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [3:0]  GATED_MASK     = 4'b0011,
  parameter logic [31:0] BYPASS_DATA    = 32'h0000_0000
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      clock_enabled_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  input  logic [3:0]                wb_sel_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      wb_rty_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,

  output logic                      thresh_cyc_o,
  output logic                      thresh_stb_o,
  output logic                      thresh_we_o,
  output logic [SUB_ADDR_WIDTH-1:0] thresh_adr_o,
  output logic [DATA_WIDTH-1:0]     thresh_dat_o,
  output logic [3:0]                thresh_sel_o,
  input  logic                      thresh_ack_i,
  input  logic                      thresh_err_i,
  input  logic                      thresh_rty_i,
  input  logic [DATA_WIDTH-1:0]     thresh_dat_i,

  output logic                      control_cyc_o,
  output logic                      control_stb_o,
  output logic                      control_we_o,
  output logic [SUB_ADDR_WIDTH-1:0] control_adr_o,
  output logic [DATA_WIDTH-1:0]     control_dat_o,
  output logic [3:0]                control_sel_o,
  input  logic                      control_ack_i,
  input  logic                      control_err_i,
  input  logic                      control_rty_i,
  input  logic [DATA_WIDTH-1:0]     control_dat_i,

  output logic                      agc_cyc_o,
  output logic                      agc_stb_o,
  output logic                      agc_we_o,
  output logic [SUB_ADDR_WIDTH-1:0] agc_adr_o,
  output logic [DATA_WIDTH-1:0]     agc_dat_o,
  output logic [3:0]                agc_sel_o,
  input  logic                      agc_ack_i,
  input  logic                      agc_err_i,
  input  logic                      agc_rty_i,
  input  logic [DATA_WIDTH-1:0]     agc_dat_i,

  output logic                      bq_cyc_o,
  output logic                      bq_stb_o,
  output logic                      bq_we_o,
  output logic [SUB_ADDR_WIDTH-1:0] bq_adr_o,
  output logic [DATA_WIDTH-1:0]     bq_dat_o,
  output logic [3:0]                bq_sel_o,
  input  logic                      bq_ack_i,
  input  logic                      bq_err_i,
  input  logic                      bq_rty_i,
  input  logic [DATA_WIDTH-1:0]     bq_dat_i
);

  state_e          state_q, state_d;
  logic [1:0]      sel_idx_q, sel_idx_d;
  logic [1:0]      req_idx;
  logic            expired;
  logic [3:0]      tgt_cyc;
  logic [3:0]      tgt_ack, tgt_err, tgt_rty;
  logic [DATA_WIDTH-1:0] tgt_dat [4];

  assign req_idx = wb_adr_i[SUB_ADDR_WIDTH +: 2];

  assign tgt_ack[SP_THRESH]  = thresh_ack_i;
  assign tgt_ack[SP_CONTROL] = control_ack_i;
  assign tgt_ack[SP_AGC]     = agc_ack_i;
  assign tgt_ack[SP_BQ]      = bq_ack_i;
  assign tgt_err[SP_THRESH]  = thresh_err_i;
  assign tgt_err[SP_CONTROL] = control_err_i;
  assign tgt_err[SP_AGC]     = agc_err_i;
  assign tgt_err[SP_BQ]      = bq_err_i;
  assign tgt_rty[SP_THRESH]  = thresh_rty_i;
  assign tgt_rty[SP_CONTROL] = control_rty_i;
  assign tgt_rty[SP_AGC]     = agc_rty_i;
  assign tgt_rty[SP_BQ]      = bq_rty_i;
  assign tgt_dat[SP_THRESH]  = thresh_dat_i;
  assign tgt_dat[SP_CONTROL] = control_dat_i;
  assign tgt_dat[SP_AGC]     = agc_dat_i;
  assign tgt_dat[SP_BQ]      = bq_dat_i;

  l1_trig_wb_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .load_i    (state_q == ST_IDLE),
    .en_i      (state_q == ST_FWD),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
    tgt_cyc   = '0;
    wb_ack_o  = 1'b0;
    wb_err_o  = 1'b0;
    wb_rty_o  = 1'b0;
    wb_dat_o  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          sel_idx_d = req_idx;
          state_d   = (GATED_MASK[req_idx] && !clock_enabled_i) ? ST_LOCAL : ST_FWD;
        end
      end
      ST_FWD: begin
        // Host abort wins over everything; timeout wins over a late target reply.
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (expired) begin
          wb_err_o = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          tgt_cyc[sel_idx_q] = 1'b1;
          if (tgt_err[sel_idx_q]) begin
            wb_err_o = 1'b1;
            wb_dat_o = tgt_dat[sel_idx_q];
            state_d  = ST_IDLE;
          end else if (tgt_rty[sel_idx_q]) begin
            wb_rty_o = 1'b1;
            wb_dat_o = tgt_dat[sel_idx_q];
            state_d  = ST_IDLE;
          end else if (tgt_ack[sel_idx_q]) begin
            wb_ack_o = 1'b1;
            wb_dat_o = tgt_dat[sel_idx_q];
            state_d  = ST_IDLE;
          end
        end
      end
      ST_LOCAL: begin
        wb_ack_o = wb_cyc_i;
        if (wb_cyc_i) begin
          wb_dat_o = BYPASS_DATA[DATA_WIDTH-1:0];
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      sel_idx_q <= SP_THRESH;
    end else begin
      state_q   <= state_d;
      sel_idx_q <= sel_idx_d;
    end
  end

  assign thresh_cyc_o  = tgt_cyc[SP_THRESH];
  assign thresh_stb_o  = tgt_cyc[SP_THRESH];
  assign control_cyc_o = tgt_cyc[SP_CONTROL];
  assign control_stb_o = tgt_cyc[SP_CONTROL];
  assign agc_cyc_o     = tgt_cyc[SP_AGC];
  assign agc_stb_o     = tgt_cyc[SP_AGC];
  assign bq_cyc_o      = tgt_cyc[SP_BQ];
  assign bq_stb_o      = tgt_cyc[SP_BQ];

  // Address, data, direction and byte selects are broadcast; only cyc/stb select.
  assign thresh_we_o   = wb_we_i;
  assign control_we_o  = wb_we_i;
  assign agc_we_o      = wb_we_i;
  assign bq_we_o       = wb_we_i;
  assign thresh_adr_o  = wb_adr_i[SUB_ADDR_WIDTH-1:0];
  assign control_adr_o = wb_adr_i[SUB_ADDR_WIDTH-1:0];
  assign agc_adr_o     = wb_adr_i[SUB_ADDR_WIDTH-1:0];
  assign bq_adr_o      = wb_adr_i[SUB_ADDR_WIDTH-1:0];
  assign thresh_dat_o  = wb_dat_i;
  assign control_dat_o = wb_dat_i;
  assign agc_dat_o     = wb_dat_i;
  assign bq_dat_o      = wb_dat_i;
  assign thresh_sel_o  = wb_sel_i;
  assign control_sel_o = wb_sel_i;
  assign agc_sel_o     = wb_sel_i;
  assign bq_sel_o      = wb_sel_i;

endmodule

// File: tb/tb_l1_trig_wb_intercon.sv
// Scoreboard bench for l1_trig_wb_intercon: host driver, target responders, monitor.
`timescale 1ns/1ps
module tb_l1_trig_wb_intercon;

  localparam int         T      = 255;
  localparam logic [3:0] GATED  = 4'b0011;
  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          start;
    int          lat;
    bit          tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ce_i;
  logic        h_cyc, h_stb, h_we;
  logic [14:0] h_adr;
  logic [31:0] h_dat;
  logic [3:0]  h_sel;
  wire         ack_o, err_o, rty_o;
  wire  [31:0] dat_o;

  wire  [3:0]  t_cyc, t_stb, t_we;
  wire  [12:0] t_adr [4];
  wire  [31:0] t_dato [4];
  wire  [3:0]  t_sel [4];
  logic [3:0]  t_ack, t_err, t_rty;
  logic [31:0] t_dati [4];

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n = 0;
  int          exp_route = -1;
  logic [12:0] exp_adr = '0;
  logic [2:0]  cfg_resp = 3'b000;
  int          cfg_delay = 0;
  logic [31:0] cfg_data = '0;
  int          rcnt = 0;

  l1_trig_wb_intercon dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .clock_enabled_i(ce_i),
    .wb_cyc_i(h_cyc), .wb_stb_i(h_stb), .wb_we_i(h_we), .wb_adr_i(h_adr),
    .wb_dat_i(h_dat), .wb_sel_i(h_sel),
    .wb_ack_o(ack_o), .wb_err_o(err_o), .wb_rty_o(rty_o), .wb_dat_o(dat_o),
    .thresh_cyc_o(t_cyc[0]), .thresh_stb_o(t_stb[0]), .thresh_we_o(t_we[0]),
    .thresh_adr_o(t_adr[0]), .thresh_dat_o(t_dato[0]), .thresh_sel_o(t_sel[0]),
    .thresh_ack_i(t_ack[0]), .thresh_err_i(t_err[0]), .thresh_rty_i(t_rty[0]),
    .thresh_dat_i(t_dati[0]),
    .control_cyc_o(t_cyc[1]), .control_stb_o(t_stb[1]), .control_we_o(t_we[1]),
    .control_adr_o(t_adr[1]), .control_dat_o(t_dato[1]), .control_sel_o(t_sel[1]),
    .control_ack_i(t_ack[1]), .control_err_i(t_err[1]), .control_rty_i(t_rty[1]),
    .control_dat_i(t_dati[1]),
    .agc_cyc_o(t_cyc[2]), .agc_stb_o(t_stb[2]), .agc_we_o(t_we[2]),
    .agc_adr_o(t_adr[2]), .agc_dat_o(t_dato[2]), .agc_sel_o(t_sel[2]),
    .agc_ack_i(t_ack[2]), .agc_err_i(t_err[2]), .agc_rty_i(t_rty[2]),
    .agc_dat_i(t_dati[2]),
    .bq_cyc_o(t_cyc[3]), .bq_stb_o(t_stb[3]), .bq_we_o(t_we[3]),
    .bq_adr_o(t_adr[3]), .bq_dat_o(t_dato[3]), .bq_sel_o(t_sel[3]),
    .bq_ack_i(t_ack[3]), .bq_err_i(t_err[3]), .bq_rty_i(t_rty[3]),
    .bq_dat_i(t_dati[3])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Reference: what the host must see for one request, from the address map rules.
  function automatic exp_t model(input logic [14:0] adr, input logic ce,
                                 input logic [2:0] resp, input int dly,
                                 input logic [31:0] rd, input int start);
    exp_t e;
    int   sub;
    sub     = int'(adr) / 8192;
    e.start = start;
    e.tmo   = 1'b0;
    e.data  = 32'h0;
    if (GATED[sub] && !ce) begin
      e.kind = K_ACK; e.lat = 1;
    end else if (resp == 3'b000 || dly > T - 2) begin
      e.kind = K_ERR; e.lat = T; e.tmo = 1'b1;
    end else begin
      e.lat  = 1 + dly;
      e.data = rd;
      if (resp[1])      e.kind = K_ERR;
      else if (resp[2]) e.kind = K_RTY;
      else              e.kind = K_ACK;
    end
    return e;
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Target models: reply with the configured response after cfg_delay strobe cycles.
  always @(posedge clk) begin
    #2;
    t_ack = '0; t_err = '0; t_rty = '0;
    for (int k = 0; k < 4; k++) t_dati[k] = {16'hBAD0, 8'(k), cyc_n[7:0]};
    if (|(t_cyc & t_stb)) begin
      for (int k = 0; k < 4; k++) begin
        if (t_cyc[k] && t_stb[k] && rcnt == cfg_delay && cfg_resp != 3'b000) begin
          t_ack[k] = cfg_resp[0];
          t_err[k] = cfg_resp[1];
          t_rty[k] = cfg_resp[2];
          t_dati[k] = cfg_data;
        end
      end
      rcnt++;
    end else begin
      rcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int   nresp, got;
      exp_t e;
      nresp = int'(ack_o) + int'(err_o) + int'(rty_o);
      if (nresp != 0) begin
        chk("resp_single", nresp, 1);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got ack=%0b err=%0b rty=%0b expected none", ack_o, err_o, rty_o);
        end else begin
          e   = exp_q.pop_front();
          got = err_o ? K_ERR : (rty_o ? K_RTY : K_ACK);
          chk("resp_kind", got, e.kind);
          chk("resp_latency", cyc_n - e.start, e.lat);
          if (e.kind == K_ACK) chk("ack_data", dat_o, e.data);
          if (e.tmo) chk("tmo_cyc_dropped", {28'h0, t_cyc}, 32'h0);
        end
      end else begin
        chk("idle_dat_zero", dat_o, 32'h0);
      end
      if (|t_cyc) begin
        chk("route_cyc", {28'h0, t_cyc}, exp_route < 0 ? 32'h0 : (32'h1 << exp_route));
        chk("stb_eq_cyc", {28'h0, t_stb}, {28'h0, t_cyc});
        for (int k = 0; k < 4; k++) begin
          if (t_cyc[k]) begin
            chk("route_adr", {19'h0, t_adr[k]}, {19'h0, exp_adr});
            chk("bcast_dat", t_dato[k], h_dat);
            chk("bcast_we_sel", {27'h0, t_we[k], t_sel[k]}, {27'h0, h_we, h_sel});
          end
        end
      end
    end
  end

  task automatic txn(input logic [14:0] adr, input logic we, input logic [31:0] wd,
                     input logic [3:0] sel, input logic ce, input logic [2:0] resp,
                     input int dly, input logic [31:0] rd);
    exp_t e;
    bit   seen;
    @(posedge clk); #1;
    e = model(adr, ce, resp, dly, rd, cyc_n);
    exp_q.push_back(e);
    cfg_resp = resp; cfg_delay = dly; cfg_data = rd; ce_i = ce;
    exp_route = (GATED[adr[14:13]] && !ce) ? -1 : int'(adr[14:13]);
    exp_adr = adr[12:0];
    h_adr = adr; h_we = we; h_dat = wd; h_sel = sel; h_cyc = 1'b1; h_stb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < T + 100 && !seen; i++) begin
      @(negedge clk);
      seen = ack_o | err_o | rty_o;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL no_response: adr 0x%04h got no response, expected one", adr);
      e = exp_q.pop_back();
    end
    @(posedge clk); #1;
    h_cyc = 1'b0; h_stb = 1'b0; exp_route = -1;
  endtask

  task automatic abort_txn(input logic [14:0] adr, input int after);
    @(posedge clk); #1;
    ce_i = 1'b1; cfg_resp = 3'b000;
    exp_route = int'(adr[14:13]); exp_adr = adr[12:0];
    h_adr = adr; h_we = 1'b0; h_dat = 32'h0; h_sel = 4'hF; h_cyc = 1'b1; h_stb = 1'b1;
    repeat (after) @(negedge clk);
    chk("abort_pre_cyc", {28'h0, t_cyc}, 32'h1 << adr[14:13]);
    @(posedge clk); #1;
    h_cyc = 1'b0; h_stb = 1'b0;
    #1;
    chk("abort_cyc_drop", {28'h0, t_cyc}, 32'h0);
    exp_route = -1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ce_i = 1'b1; h_cyc = 1'b0; h_stb = 1'b0; h_we = 1'b0;
    h_adr = '0; h_dat = '0; h_sel = '0;
    t_ack = '0; t_err = '0; t_rty = '0;
    for (int k = 0; k < 4; k++) t_dati[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cyc", {28'h0, t_cyc}, 32'h0);
    chk("reset_resp", {29'h0, ack_o, err_o, rty_o}, 32'h0);
    chk("reset_dat", dat_o, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    txn(15'h0004, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 3'b001, 2, 32'h0);
    txn(15'h6010, 1'b0, 32'h0, 4'hF, 1'b1, 3'b001, 0, 32'hCAFE_F00D);
    txn(15'h4000, 1'b0, 32'h0, 4'h3, 1'b1, 3'b001, 1, 32'h0BAD_CAFE);
    txn(15'h2008, 1'b0, 32'h0, 4'hF, 1'b0, 3'b001, 0, 32'h5555_AAAA);
    txn(15'h4008, 1'b0, 32'h0, 4'hF, 1'b0, 3'b001, 1, 32'h7777_1111);
    txn(15'h0010, 1'b0, 32'h0, 4'hF, 1'b1, 3'b000, 0, 32'h0);
    txn(15'h0014, 1'b0, 32'h0, 4'hF, 1'b1, 3'b001, 0, 32'h1357_9BDF);
    txn(15'h4100, 1'b0, 32'h0, 4'hF, 1'b1, 3'b011, 1, 32'hDEAD_BEEF);
    txn(15'h2100, 1'b0, 32'h0, 4'hF, 1'b1, 3'b101, 0, 32'hFEED_0001);
    abort_txn(15'h6020, 2);

    for (int i = 0; i < 40; i++) begin
      txn(15'($urandom), 1'($urandom), $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
          3'($urandom_range(1, 7)), $urandom_range(0, 5), $urandom);
    end
    txn({2'($urandom_range(2, 3)), 13'($urandom)}, 1'b0, 32'h0, 4'hF, 1'b0, 3'b000, 0, 32'h0);
    txn(15'($urandom), 1'b1, $urandom, 4'hF, 1'b1, 3'b001, 3, $urandom);

    // Asynchronous reset in the middle of a forwarded access.
    @(posedge clk); #1;
    ce_i = 1'b1; cfg_resp = 3'b000; exp_route = 0; exp_adr = 13'h0004;
    h_adr = 15'h0004; h_we = 1'b0; h_sel = 4'hF; h_cyc = 1'b1; h_stb = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_cyc", {28'h0, t_cyc}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", {28'h0, t_cyc}, 32'h0);
    chk("async_rst_resp", {29'h0, ack_o, err_o, rty_o}, 32'h0);
    chk("async_rst_dat", dat_o, 32'h0);
    h_cyc = 1'b0; h_stb = 1'b0; exp_route = -1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn(15'h0004, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 3'b001, 2, 32'h0);

    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
